// File: rtl/level_score_ctrl_if.sv
// Link between the finish-line block and the game-flow controller.
// The finish-line side reports occupied homes and level completion and
// receives the game-reset request back.
interface level_score_ctrl_if;
    logic [4:0] FrogFinished;
    logic       GoNextLevel;
    logic       ResetGame;

    modport master (
        output FrogFinished,
        output GoNextLevel,
        input  ResetGame
    );

    modport slave (
        input  FrogFinished,
        input  GoNextLevel,
        output ResetGame
    );
endinterface

// File: rtl/level_score_ctrl.sv
// Game-flow controller: runs IDLE/PLAY/LEVEL_UP/GAME_OVER, keeps score,
// lives and level, and drives freeze/respawn and the finish-line reset.
module level_score_ctrl #(
    parameter int unsigned START_LIVES     = 3,
    parameter int unsigned MAX_LEVEL       = 9,
    parameter int unsigned LEVELUP_FRAMES  = 120,
    parameter int unsigned GAMEOVER_FRAMES = 180,
    parameter int unsigned HOME_POINTS     = 50,
    parameter int unsigned LEVEL_BONUS     = 1000,
    parameter int unsigned SCORE_MAX       = 9999
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 frame_clk_rising_edge,
    input  logic                 start_key,
    input  logic                 frog_died,
    level_score_ctrl_if.slave    fin_if,
    output logic [3:0]           Level,
    output logic [2:0]           Lives,
    output logic [13:0]          Score,
    output logic [1:0]           game_state,
    output logic                 freeze,
    output logic                 frog_respawn
);

    localparam int unsigned MaxFrames =
        (LEVELUP_FRAMES > GAMEOVER_FRAMES) ? LEVELUP_FRAMES : GAMEOVER_FRAMES;
    localparam int unsigned CntW = (MaxFrames > 1) ? $clog2(MaxFrames) : 1;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StPlay     = 2'd1,
        StLevelUp  = 2'd2,
        StGameOver = 2'd3
    } state_e;

    state_e            r_state, w_state_nxt;
    logic [3:0]        r_level, w_level_nxt;
    logic [2:0]        r_lives, w_lives_nxt;
    logic [13:0]       r_score, w_score_nxt;
    logic [CntW-1:0]   r_cnt, w_cnt_nxt;
    logic              r_reset_game, w_reset_game_nxt;
    logic              r_freeze, w_freeze_nxt;
    logic              r_respawn, w_respawn_nxt;
    logic [4:0]        r_prev_fin;
    logic              r_prev_gnl;
    logic              r_prev_start;

    logic [4:0]        w_new_homes;
    logic              w_lvl_evt;
    logic              w_start_evt;
    logic [2:0]        w_pop;
    logic [14:0]       w_sum;

    assign w_new_homes = fin_if.FrogFinished & ~r_prev_fin;
    assign w_lvl_evt   = fin_if.GoNextLevel & ~r_prev_gnl;
    assign w_start_evt = start_key & ~r_prev_start;

    // Count newly occupied homes this cycle.
    always_comb begin
        w_pop = 3'd0;
        for (int i = 0; i < 5; i++) begin
            w_pop = w_pop + {2'b00, w_new_homes[i]};
        end
    end

    // Score sum is kept one bit wider so saturation can never wrap.
    assign w_sum = {1'b0, r_score}
                 + 15'(w_pop) * 15'(HOME_POINTS)
                 + (w_lvl_evt ? 15'(HOME_POINTS + LEVEL_BONUS) : 15'd0);

    // State register plus all registered outputs and edge-detect history.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state      <= StIdle;
            r_level      <= 4'd1;
            r_lives      <= 3'(START_LIVES);
            r_score      <= 14'd0;
            r_cnt        <= '0;
            r_reset_game <= 1'b1;
            r_freeze     <= 1'b1;
            r_respawn    <= 1'b0;
            r_prev_fin   <= 5'd0;
            r_prev_gnl   <= 1'b0;
            r_prev_start <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_level      <= w_level_nxt;
            r_lives      <= w_lives_nxt;
            r_score      <= w_score_nxt;
            r_cnt        <= w_cnt_nxt;
            r_reset_game <= w_reset_game_nxt;
            r_freeze     <= w_freeze_nxt;
            r_respawn    <= w_respawn_nxt;
            r_prev_fin   <= fin_if.FrogFinished;
            r_prev_gnl   <= fin_if.GoNextLevel;
            r_prev_start <= start_key;
        end
    end

    // Next-state, counters and output decode.
    always_comb begin
        w_state_nxt   = r_state;
        w_level_nxt   = r_level;
        w_lives_nxt   = r_lives;
        w_score_nxt   = r_score;
        w_cnt_nxt     = r_cnt;
        w_respawn_nxt = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (w_start_evt) begin
                    w_state_nxt   = StPlay;
                    w_score_nxt   = 14'd0;
                    w_level_nxt   = 4'd1;
                    w_lives_nxt   = 3'(START_LIVES);
                    w_respawn_nxt = 1'b1;
                end
            end
            StPlay: begin
                w_score_nxt = (w_sum > 15'(SCORE_MAX)) ? 14'(SCORE_MAX) : w_sum[13:0];
                if (w_new_homes != 5'd0) begin
                    w_respawn_nxt = 1'b1;
                end
                // Level completion beats a simultaneous death.
                if (w_lvl_evt) begin
                    w_state_nxt = StLevelUp;
                    w_cnt_nxt   = '0;
                end else if (frog_died) begin
                    if (r_lives > 3'd1) begin
                        w_lives_nxt   = r_lives - 3'd1;
                        w_respawn_nxt = 1'b1;
                    end else begin
                        w_lives_nxt = 3'd0;
                        w_state_nxt = StGameOver;
                        w_cnt_nxt   = '0;
                    end
                end
            end
            StLevelUp: begin
                if (frame_clk_rising_edge) begin
                    if (r_cnt == CntW'(LEVELUP_FRAMES - 1)) begin
                        w_level_nxt   = (r_level >= 4'(MAX_LEVEL)) ? r_level : r_level + 4'd1;
                        w_respawn_nxt = 1'b1;
                        w_state_nxt   = StPlay;
                        w_cnt_nxt     = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            end
            StGameOver: begin
                if (frame_clk_rising_edge) begin
                    if (r_cnt == CntW'(GAMEOVER_FRAMES - 1)) begin
                        w_state_nxt = StIdle;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            end
            default: w_state_nxt = StIdle;
        endcase

        w_reset_game_nxt = (w_state_nxt == StIdle) || (w_state_nxt == StGameOver);
        w_freeze_nxt     = (w_state_nxt != StPlay);
    end

    assign fin_if.ResetGame = r_reset_game;
    assign Level            = r_level;
    assign Lives            = r_lives;
    assign Score            = r_score;
    assign game_state       = r_state;
    assign freeze           = r_freeze;
    assign frog_respawn     = r_respawn;

endmodule

// File: tb/tb_level_score_ctrl.sv
// Bench for level_score_ctrl: a reference model predicts every cycle's
// registered outputs into a scoreboard queue, popped after each clock edge.
module tb_level_score_ctrl;

    localparam int StartLives = 3;
    localparam int MaxLevel   = 9;
    localparam int LvlFrames  = 120;
    localparam int GoFrames   = 180;
    localparam int HomePts    = 50;
    localparam int Bonus      = 1000;
    localparam int ScoreMax   = 9999;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        frame_clk_rising_edge;
    logic        start_key;
    logic        frog_died;
    logic [3:0]  Level;
    logic [2:0]  Lives;
    logic [13:0] Score;
    logic [1:0]  game_state;
    logic        freeze;
    logic        frog_respawn;

    level_score_ctrl_if fin_if ();

    level_score_ctrl dut (
        .Clk                   (Clk),
        .Reset                 (Reset),
        .frame_clk_rising_edge (frame_clk_rising_edge),
        .start_key             (start_key),
        .frog_died             (frog_died),
        .fin_if                (fin_if),
        .Level                 (Level),
        .Lives                 (Lives),
        .Score                 (Score),
        .game_state            (game_state),
        .freeze                (freeze),
        .frog_respawn          (frog_respawn)
    );

    always #10 Clk = ~Clk;

    typedef struct {
        int st;
        int lvl;
        int lives;
        int score;
        int rg;
        int frz;
        int resp;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model state (register images after the next edge).
    int m_state, m_score, m_level, m_lives, m_cnt;
    int m_pfin, m_pgnl, m_pst, m_resp;

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    endtask

    task automatic model_step();
        int nh, pop, sum, lvl, sev;
        if (Reset) begin
            m_state = 0; m_score = 0; m_level = 1; m_lives = StartLives; m_cnt = 0;
            m_pfin = 0; m_pgnl = 0; m_pst = 0; m_resp = 0;
        end else begin
            nh  = int'(fin_if.FrogFinished) & ~m_pfin & 31;
            pop = 0;
            for (int b = 0; b < 5; b++) pop += (nh >> b) & 1;
            lvl = (fin_if.GoNextLevel && m_pgnl == 0) ? 1 : 0;
            sev = (start_key && m_pst == 0) ? 1 : 0;
            m_resp = 0;
            case (m_state)
                0: if (sev == 1) begin
                    m_state = 1; m_score = 0; m_level = 1; m_lives = StartLives; m_resp = 1;
                end
                1: begin
                    sum = m_score + pop * HomePts + ((lvl == 1) ? HomePts + Bonus : 0);
                    m_score = (sum > ScoreMax) ? ScoreMax : sum;
                    if (pop > 0) m_resp = 1;
                    if (lvl == 1) begin
                        m_state = 2; m_cnt = 0;
                    end else if (frog_died) begin
                        if (m_lives > 1) begin
                            m_lives--; m_resp = 1;
                        end else begin
                            m_lives = 0; m_state = 3; m_cnt = 0;
                        end
                    end
                end
                2: if (frame_clk_rising_edge) begin
                    if (m_cnt == LvlFrames - 1) begin
                        m_level = (m_level + 1 > MaxLevel) ? MaxLevel : m_level + 1;
                        m_resp = 1; m_state = 1; m_cnt = 0;
                    end else m_cnt++;
                end
                default: if (frame_clk_rising_edge) begin
                    if (m_cnt == GoFrames - 1) begin
                        m_state = 0; m_cnt = 0;
                    end else m_cnt++;
                end
            endcase
            m_pfin = int'(fin_if.FrogFinished);
            m_pgnl = int'(fin_if.GoNextLevel);
            m_pst  = int'(start_key);
        end
    endtask

    // One clock: predict, push, clock, pop, compare.
    task automatic cyc();
        exp_t e;
        model_step();
        e.st    = m_state;
        e.lvl   = m_level;
        e.lives = m_lives;
        e.score = m_score;
        e.rg    = (m_state == 0 || m_state == 3) ? 1 : 0;
        e.frz   = (m_state != 1) ? 1 : 0;
        e.resp  = m_resp;
        sb.push_back(e);
        @(posedge Clk);
        #1;
        e = sb.pop_front();
        check_val("state",     int'(game_state),       e.st);
        check_val("level",     int'(Level),            e.lvl);
        check_val("lives",     int'(Lives),            e.lives);
        check_val("score",     int'(Score),            e.score);
        check_val("resetgame", int'(fin_if.ResetGame), e.rg);
        check_val("freeze",    int'(freeze),           e.frz);
        check_val("respawn",   int'(frog_respawn),     e.resp);
    endtask

    task automatic run_frames(input int n);
        for (int i = 0; i < n; i++) begin
            frame_clk_rising_edge = i[0];
            cyc();
        end
        frame_clk_rising_edge = 1'b0;
    endtask

    task automatic pulse_died();
        frog_died = 1'b1;
        cyc();
        frog_died = 1'b0;
    endtask

    task automatic level_up();
        fin_if.FrogFinished = 5'd0;
        fin_if.GoNextLevel  = 1'b1;
        cyc();
        cyc();
        fin_if.GoNextLevel = 1'b0;
        run_frames(2 * LvlFrames);
        cyc();
    endtask

    initial begin
        Reset                 = 1'b1;
        frame_clk_rising_edge = 1'b0;
        start_key             = 1'b0;
        frog_died             = 1'b0;
        fin_if.FrogFinished   = 5'd0;
        fin_if.GoNextLevel    = 1'b0;
        cyc();
        cyc();
        check_val("rst_state", int'(game_state), 0);
        check_val("rst_lives", int'(Lives), StartLives);
        Reset = 1'b0;
        cyc();

        // Start the game.
        start_key = 1'b1;
        cyc();
        check_val("start_state", int'(game_state), 1);
        check_val("start_resp", int'(frog_respawn), 1);
        cyc();
        check_val("start_resp_once", int'(frog_respawn), 0);

        // Two homes at once, then hold.
        fin_if.FrogFinished = 5'b00101;
        cyc();
        check_val("homes_score", int'(Score), 100);
        run_frames(20);
        check_val("homes_hold", int'(Score), 100);
        fin_if.FrogFinished = 5'b01111;
        cyc();

        // First level completion, deaths and home changes ignored while paused.
        fin_if.FrogFinished = 5'd0;
        fin_if.GoNextLevel  = 1'b1;
        cyc();
        check_val("lvl_score", int'(Score), 1250);
        check_val("lvl_state", int'(game_state), 2);
        cyc();
        fin_if.GoNextLevel = 1'b0;
        run_frames(10);
        pulse_died();
        fin_if.FrogFinished = 5'b10000;
        run_frames(10);
        fin_if.FrogFinished = 5'd0;
        run_frames(2 * LvlFrames - 20);
        cyc();
        check_val("lvl2_level", int'(Level), 2);
        check_val("lvl2_state", int'(game_state), 1);
        check_val("lvl2_lives", int'(Lives), 3);

        // Walk up to and past the level ceiling.
        for (int k = 0; k < 8; k++) level_up();
        check_val("lvl_sat", int'(Level), MaxLevel);
        check_val("score_9650", int'(Score), 9650);

        // Score saturation.
        fin_if.FrogFinished = 5'b11111;
        cyc();
        fin_if.FrogFinished = 5'd0;
        cyc();
        fin_if.FrogFinished = 5'b00011;
        cyc();
        check_val("score_sat", int'(Score), ScoreMax);
        fin_if.FrogFinished = 5'd0;
        cyc();

        // Lose two lives, then die on the same cycle as level completion.
        pulse_died();
        cyc();
        pulse_died();
        check_val("lives_one", int'(Lives), 1);
        frog_died          = 1'b1;
        fin_if.GoNextLevel = 1'b1;
        cyc();
        frog_died = 1'b0;
        check_val("tie_state", int'(game_state), 2);
        check_val("tie_lives", int'(Lives), 1);
        cyc();
        fin_if.GoNextLevel = 1'b0;
        run_frames(60);

        // Reset in the middle of the level-up pause.
        Reset     = 1'b1;
        start_key = 1'b0;
        cyc();
        Reset = 1'b0;
        check_val("mid_rst_state", int'(game_state), 0);
        check_val("mid_rst_level", int'(Level), 1);
        check_val("mid_rst_score", int'(Score), 0);
        cyc();

        // New game to game over; start presses ignored while over.
        start_key = 1'b1;
        cyc();
        cyc();
        pulse_died();
        cyc();
        pulse_died();
        cyc();
        pulse_died();
        check_val("go_state", int'(game_state), 3);
        check_val("go_lives", int'(Lives), 0);
        check_val("go_rg", int'(fin_if.ResetGame), 1);
        for (int i = 0; i < 2 * GoFrames; i++) begin
            frame_clk_rising_edge = i[0];
            start_key             = ((i % 16) < 8);
            cyc();
            if (i == 200) check_val("go_start_ignored", int'(game_state), 3);
        end
        frame_clk_rising_edge = 1'b0;
        check_val("go_idle", int'(game_state), 0);
        cyc();
        check_val("idle_hold", int'(game_state), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/level_score_ctrl.md
Name: level_score_ctrl

Overview:
Game-flow controller sitting directly downstream of the finish-line block. Consumes its completed-homes vector (FrogFinished) and level-complete flag (GoNextLevel), plus the frog death pulse, and runs the game state machine. Maintains score, lives and level, and drives ResetGame back into the finish-line block. Also supplies freeze/respawn control to the frog and level to the lane/obstacle speed logic.

Parameters:
START_LIVES, 3, lives loaded at game start (1..7)
MAX_LEVEL, 9, level saturation value (1..15)
LEVELUP_FRAMES, 120, frames spent in LEVEL_UP pause
GAMEOVER_FRAMES, 180, frames spent in GAME_OVER before IDLE
HOME_POINTS, 50, points per newly occupied home
LEVEL_BONUS, 1000, extra points on level completion
SCORE_MAX, 9999, score saturation value

Ports:
Clk  in  1  50 MHz system clock
Reset  in  1  synchronous, active-high
frame_clk_rising_edge  in  1  one-Clk pulse per frame (~60 Hz)
start_key  in  1  start request, level-sensitive, already synchronized
FrogFinished  in  5  occupied-homes vector from finish-line block
GoNextLevel  in  1  level-complete flag from finish-line block (held up to one frame)
frog_died  in  1  one-Clk pulse on frog death
ResetGame  out  1  clears finish-line state
Level  out  4  current level, 1..MAX_LEVEL
Lives  out  3  remaining lives
Score  out  14  binary score, 0..SCORE_MAX
game_state  out  2  IDLE=0, PLAY=1, LEVEL_UP=2, GAME_OVER=3
freeze  out  1  frog/obstacle motion hold
frog_respawn  out  1  one-Clk pulse: return frog to start position

Behaviour:
- Reset/clock: Reset is synchronous, active-high; clock is Clk. All outputs are registered.
- Reset values: state IDLE, ResetGame=1, Level=1, Lives=START_LIVES, Score=0, freeze=1, frog_respawn=0, frame counter=0, edge-detect registers=0.
- Internal registers: prev_fin (5b) <= FrogFinished every Clk; prev_gnl <= GoNextLevel every Clk; prev_start <= start_key every Clk.
- Derived events:
  - new_homes = FrogFinished & ~prev_fin.
  - lvl_evt = GoNextLevel & ~prev_gnl.
  - start_evt = start_key & ~prev_start.
- IDLE:
  - ResetGame=1, freeze=1. Score, Level and Lives hold their last values for display.
  - start_evt -> PLAY next Clk, with Score=0, Level=1, Lives=START_LIVES, frog_respawn pulse.
- PLAY:
  - ResetGame=0, freeze=0.
  - Per Clk: Score += popcount(new_homes)*HOME_POINTS. If any new_homes bit is set, pulse frog_respawn.
  - lvl_evt: the fifth home never appears on FrogFinished, because the upstream block clears the vector on completion. Score += HOME_POINTS+LEVEL_BONUS, -> LEVEL_UP, frame counter=0.
  - frog_died without lvl_evt:
    - If Lives>1: Lives-1, frog_respawn pulse.
    - If Lives==1: Lives=0, -> GAME_OVER, frame counter=0.
  - frog_died and lvl_evt in the same Clk: level-up wins; the death is ignored.
  - new_homes and lvl_evt in the same Clk: both additions apply in that Clk.
- LEVEL_UP:
  - freeze=1, ResetGame=0. Frame counter increments on frame_clk_rising_edge.
  - On the edge where counter==LEVELUP_FRAMES-1: Level=min(Level+1, MAX_LEVEL), frog_respawn pulse, -> PLAY.
  - frog_died and FrogFinished changes are ignored.
- GAME_OVER:
  - freeze=1, ResetGame=1. Counts frames as in LEVEL_UP.
  - At GAMEOVER_FRAMES -> IDLE. start_key is ignored.
- Score arithmetic: computed in 15 bits, then saturated to SCORE_MAX; never wraps. Level saturates at MAX_LEVEL, never wraps to 0. Lives never underflow.
- Latency: one Clk from the input event to the updated outputs/state.
- frog_respawn is high for exactly one Clk per event.
- Reset mid-operation (any state, any counter value): next Clk equals the reset values; pending edge detects are discarded.

Test Plan:
- Reset then start_key 0->1 -> next Clk game_state=1, Score=0, Level=1, Lives=3, ResetGame=0, freeze=0, one-Clk frog_respawn.
- In PLAY, FrogFinished 00000->00101 in one Clk -> Score +100, one respawn pulse; holding FrogFinished=00101 for 10 frames -> no further change.
- FrogFinished=01111, then GoNextLevel=1 held 1 frame with FrogFinished=00000 -> Score +1050 once, game_state=2, freeze=1. After 120 frame edges: Level=2, state=1, respawn pulse.
- Lives=1 and frog_died pulse -> Lives=0, game_state=3, ResetGame=1. After 180 frames -> IDLE; start_key during GAME_OVER has no effect.
- Saturation: Score=9980, two new homes -> Score=9999. Level=9, level complete -> Level stays 9.
- Simultaneous frog_died and GoNextLevel rising edge with Lives=1 -> LEVEL_UP entered, Lives stays 1. Reset asserted mid-LEVEL_UP -> IDLE, Level=1, Score=0.
